// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
// Shared types and helpers for the CPU pin bus bridge.
//   bus_state_t      : bridge FSM state encoding
//   num_addr_beats() : byte beats needed to carry an address of the given width
//   num_data_beats() : byte beats needed to carry a data word of the given width
//   UIO_*            : bit positions for packing the bus strobes into uio_out
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } bus_state_t;

    function automatic int num_addr_beats(input int aw);
        return (aw + 7) / 8;
    endfunction

    function automatic int num_data_beats(input int dw);
        return dw / 8;
    endfunction

    // uio_out layout used by the tt_um wrapper
    localparam int UIO_ALE_BIT  = 0;
    localparam int UIO_WR_BIT   = 1;
    localparam int UIO_RD_BIT   = 2;
    localparam int UIO_BEAT_LSB = 3;
    localparam int UIO_BEAT_W   = 3;

endpackage

// File: rtl/cpu_pin_bus_bridge_timer.sv
// bus_beat_timer
// Beat index counter plus the data-beat timeout down-counter.
//   beat_clr   : zero the beat index and reload the timeout
//   beat_adv   : step the beat index and reload the timeout
//   tmo_run    : a data beat is waiting for its acknowledge this cycle
//   beat       : current beat index (registered)
//   beat_nxt   : beat index after this edge, used to pre-compute registered outputs
//   tmo_expire : the waiting beat has used up its TIMEOUT cycles (never when TIMEOUT = 0)
module bus_beat_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beat_clr,
    input  logic       beat_adv,
    input  logic       tmo_run,
    output logic [2:0] beat,
    output logic [2:0] beat_nxt,
    output logic       tmo_expire
);

    // Loading TIMEOUT-1 and expiring on zero makes the strobe stay high
    // for exactly TIMEOUT cycles before the abort edge.
    localparam logic [7:0] TMO_LOAD = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;
    localparam bit         TMO_EN   = (TIMEOUT > 0);

    logic [2:0] beat_q, beat_d;
    logic [7:0] tmo_q, tmo_d;

    always_comb begin
        beat_d = beat_q;
        tmo_d  = tmo_q;
        if (beat_clr) begin
            beat_d = 3'd0;
            tmo_d  = TMO_LOAD;
        end else if (beat_adv) begin
            beat_d = beat_q + 3'd1;
            tmo_d  = TMO_LOAD;
        end else if (tmo_run && (tmo_q != 8'd0)) begin
            tmo_d = tmo_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= 3'd0;
            tmo_q  <= 8'd0;
        end else begin
            beat_q <= beat_d;
            tmo_q  <= tmo_d;
        end
    end

    assign beat       = beat_q;
    assign beat_nxt   = beat_d;
    assign tmo_expire = TMO_EN && tmo_run && (tmo_q == 8'd0);

endmodule

// File: rtl/cpu_pin_bus_bridge.sv
// cpu_pin_bus_bridge
// Serialises CPU memory accesses onto the 8-bit pad bus: address bytes first
// (one cycle each, bus_ale), then data bytes (bus_wr / bus_rd), each data byte
// closed by ext_ack or aborted by the beat timeout.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for cpu_req; latches address, data and direction
// ADDR  | one address byte per cycle, LSB first
// WDATA | write byte on bus_out, waiting for ext_ack per byte
// RDATA | read strobe, bus_in captured on each ext_ack
// DONE  | one-cycle cpu_ready with cpu_rdata / cpu_err valid
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   cpu_req/write/addr/wdata   : CPU access request (held until cpu_ready)
//   cpu_rdata/ready/err        : completion pulse, read data, timeout flag
//   busy                       : access in progress (accept through DONE)
//   bus_out/bus_in             : pad data out / in
//   bus_ale/bus_wr/bus_rd      : address / write / read beat strobes
//   bus_beat                   : byte index within the current phase
//   ext_ack                    : external device completes a data beat
module cpu_pin_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    output logic          cpu_err,
    output logic          busy,
    output logic [7:0]    bus_out,
    input  logic [7:0]    bus_in,
    output logic          bus_ale,
    output logic          bus_wr,
    output logic          bus_rd,
    output logic [2:0]    bus_beat,
    input  logic          ext_ack
);

    localparam int         NA     = num_addr_beats(AW);
    localparam int         NB     = num_data_beats(DW);
    localparam logic [2:0] LAST_A = 3'(NA - 1);
    localparam logic [2:0] LAST_D = 3'(NB - 1);

    bus_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic [DW-1:0] rbuf_q, rbuf_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [7:0]    bus_out_q, bus_out_d;
    logic          ale_q, ale_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [2:0]    beat_o_q, beat_o_d;

    logic [2:0]    beat_q, beat_nxt;
    logic          tmo_expire;
    logic          beat_clr, beat_adv, tmo_run;
    logic          in_data, last_a, last_d;
    logic [NA*8-1:0] addr_pad;

    assign in_data = (state_q == ST_WDATA) || (state_q == ST_RDATA);
    assign last_a  = (beat_q == LAST_A);
    assign last_d  = (beat_q == LAST_D);

    // Timer controls are plain decodes of the current state so the FSM and
    // output logic can consume the timer's next-beat value without a loop.
    assign beat_clr = ((state_q == ST_IDLE) && cpu_req) || ((state_q == ST_ADDR) && last_a);
    assign beat_adv = ((state_q == ST_ADDR) && !last_a) || (in_data && ext_ack && !last_d);
    assign tmo_run  = in_data && !ext_ack;

    bus_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_clr   (beat_clr),
        .beat_adv   (beat_adv),
        .tmo_run    (tmo_run),
        .beat       (beat_q),
        .beat_nxt   (beat_nxt),
        .tmo_expire (tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    write_d = cpu_write;
                    err_d   = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (last_a) begin
                    state_d = write_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA, ST_RDATA: begin
                // ack is checked first so it wins over a same-edge expiry
                if (ext_ack) begin
                    if (state_q == ST_RDATA) begin
                        for (int i = 0; i < NB; i++) begin
                            if (beat_q == 3'(i)) begin
                                rbuf_d[i*8 +: 8] = bus_in;
                            end
                        end
                    end
                    if (last_d) begin
                        state_d = ST_DONE;
                        if (state_q == ST_RDATA) begin
                            rdata_d = rbuf_d;
                        end
                    end
                end else if (tmo_expire) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are computed from the next state and
    // next beat index; the pads then change on the same edge as the state.
    always_comb begin
        ale_d    = (state_d == ST_ADDR);
        wr_d     = (state_d == ST_WDATA);
        rd_d     = (state_d == ST_RDATA);
        busy_d   = (state_d != ST_IDLE);
        ready_d  = (state_d == ST_DONE);
        beat_o_d = (ale_d || wr_d || rd_d) ? beat_nxt : 3'd0;

        addr_pad           = '0;
        addr_pad[AW-1:0]   = addr_d;

        bus_out_d = 8'd0;
        if (ale_d) begin
            for (int i = 0; i < NA; i++) begin
                if (beat_nxt == 3'(i)) begin
                    bus_out_d = addr_pad[i*8 +: 8];
                end
            end
        end else if (wr_d) begin
            for (int i = 0; i < NB; i++) begin
                if (beat_nxt == 3'(i)) begin
                    bus_out_d = wdata_d[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            rbuf_q    <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            bus_out_q <= 8'd0;
            ale_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            beat_o_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            rbuf_q    <= rbuf_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            bus_out_q <= bus_out_d;
            ale_q     <= ale_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            beat_o_q  <= beat_o_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_err   = err_q;
    assign busy      = busy_q;
    assign bus_out   = bus_out_q;
    assign bus_ale   = ale_q;
    assign bus_wr    = wr_q;
    assign bus_rd    = rd_q;
    assign bus_beat  = beat_o_q;

endmodule

// File: tb/tb_cpu_pin_bus_bridge.sv
// Directed bench: instance A uses default parameters (AW=16, DW=8, TIMEOUT=15),
// instance B uses AW=12, DW=16, TIMEOUT=4. Outputs are sampled on the falling
// edge; inputs are driven right after that sample.
module tb_cpu_pin_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance A
    logic        a_rst_n, a_req, a_write, a_ready, a_err, a_busy;
    logic [15:0] a_addr;
    logic [7:0]  a_wdata, a_rdata, a_bus_out, a_bus_in;
    logic        a_ale, a_wr, a_rd, a_ack;
    logic [2:0]  a_beat;

    // instance B
    logic        b_rst_n, b_req, b_write, b_ready, b_err, b_busy;
    logic [11:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [7:0]  b_bus_out, b_bus_in;
    logic        b_ale, b_wr, b_rd, b_ack;
    logic [2:0]  b_beat;

    cpu_pin_bus_bridge u_a (
        .clk(clk), .rst_n(a_rst_n), .cpu_req(a_req), .cpu_write(a_write),
        .cpu_addr(a_addr), .cpu_wdata(a_wdata), .cpu_rdata(a_rdata),
        .cpu_ready(a_ready), .cpu_err(a_err), .busy(a_busy),
        .bus_out(a_bus_out), .bus_in(a_bus_in), .bus_ale(a_ale),
        .bus_wr(a_wr), .bus_rd(a_rd), .bus_beat(a_beat), .ext_ack(a_ack)
    );

    cpu_pin_bus_bridge #(.AW(12), .DW(16), .TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(b_rst_n), .cpu_req(b_req), .cpu_write(b_write),
        .cpu_addr(b_addr), .cpu_wdata(b_wdata), .cpu_rdata(b_rdata),
        .cpu_ready(b_ready), .cpu_err(b_err), .busy(b_busy),
        .bus_out(b_bus_out), .bus_in(b_bus_in), .bus_ale(b_ale),
        .bus_wr(b_wr), .bus_rd(b_rd), .bus_beat(b_beat), .ext_ack(b_ack)
    );

    // {ale, wr, rd, ready, busy, beat[2:0], bus_out[7:0]}
    function automatic logic [15:0] pk(input logic ale, input logic wr, input logic rd,
                                       input logic rdy, input logic bsy,
                                       input logic [2:0] bt, input logic [7:0] o);
        return {ale, wr, rd, rdy, bsy, bt, o};
    endfunction

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_bus_in = '0; a_ack = 0;
        b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_bus_in = '0; b_ack = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_rdata, a_ready, a_err, a_busy, a_bus_out, a_ale, a_wr, a_rd, a_beat} !== 31'd0) begin
            errors++;
            $display("FAIL reset_a: got %h want 0",
                     {a_rdata, a_ready, a_err, a_busy, a_bus_out, a_ale, a_wr, a_rd, a_beat});
        end
        checks++;
        if ({b_rdata, b_ready, b_err, b_busy, b_bus_out, b_ale, b_wr, b_rd, b_beat} !== 39'd0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0",
                     {b_rdata, b_ready, b_err, b_busy, b_bus_out, b_ale, b_wr, b_rd, b_beat});
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_busy, a_ale, a_ready} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000", {a_busy, a_ale, a_ready});
        end
    endtask

    task automatic test_write_default();
        logic [15:0] exp;
        a_req = 1; a_write = 1; a_addr = 16'h1234; a_wdata = 8'hA5; a_ack = 1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            case (cyc)
                1:       exp = pk(1, 0, 0, 0, 1, 3'd0, 8'h34);
                2:       exp = pk(1, 0, 0, 0, 1, 3'd1, 8'h12);
                3:       exp = pk(0, 1, 0, 0, 1, 3'd0, 8'hA5);
                4:       exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
                default: exp = 16'h0000;
            endcase
            checks++;
            if ({a_ale, a_wr, a_rd, a_ready, a_busy, a_beat, a_bus_out} !== exp) begin
                errors++;
                $display("FAIL write_default cyc%0d: got %h want %h", cyc,
                         {a_ale, a_wr, a_rd, a_ready, a_busy, a_beat, a_bus_out}, exp);
            end
            if (cyc == 4) begin
                checks++;
                if (a_err !== 1'b0) begin
                    errors++;
                    $display("FAIL write_default err: got %b want 0", a_err);
                end
                a_req = 0;
            end
        end
        a_ack = 0;
    endtask

    task automatic test_read_delayed();
        logic [15:0] exp;
        b_req = 1; b_write = 0; b_addr = 12'h5A3; b_ack = 0; b_bus_in = 8'hCD;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1)      exp = pk(1, 0, 0, 0, 1, 3'd0, 8'hA3);
            else if (cyc == 2) exp = pk(1, 0, 0, 0, 1, 3'd1, 8'h05);
            else if (cyc <= 5) exp = pk(0, 0, 1, 0, 1, 3'd0, 8'h00);
            else if (cyc <= 8) exp = pk(0, 0, 1, 0, 1, 3'd1, 8'h00);
            else if (cyc == 9) exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
            else               exp = 16'h0000;
            checks++;
            if ({b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out} !== exp) begin
                errors++;
                $display("FAIL read_delayed cyc%0d: got %h want %h", cyc,
                         {b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out}, exp);
            end
            if (cyc == 8) begin
                checks++;
                if (b_rdata !== 16'h0000) begin
                    errors++;
                    $display("FAIL read_delayed rdata_before_done: got %h want 0000", b_rdata);
                end
            end
            if (cyc == 9) begin
                checks++;
                if ({b_rdata, b_err} !== {16'hABCD, 1'b0}) begin
                    errors++;
                    $display("FAIL read_delayed rdata/err: got %h/%b want abcd/0", b_rdata, b_err);
                end
                b_req = 0;
            end
            b_ack    = (cyc == 5) || (cyc == 8);
            b_bus_in = (cyc < 5) ? 8'hCD : ((cyc == 5) ? 8'hCD : 8'hAB);
        end
        b_ack = 0;
    endtask

    task automatic test_timeout();
        logic [15:0] exp;
        b_req = 1; b_write = 0; b_addr = 12'h0A0; b_ack = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1)      exp = pk(1, 0, 0, 0, 1, 3'd0, 8'hA0);
            else if (cyc == 2) exp = pk(1, 0, 0, 0, 1, 3'd1, 8'h00);
            else if (cyc <= 6) exp = pk(0, 0, 1, 0, 1, 3'd0, 8'h00);
            else if (cyc == 7) exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
            else               exp = 16'h0000;
            checks++;
            if ({b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out} !== exp) begin
                errors++;
                $display("FAIL timeout cyc%0d: got %h want %h", cyc,
                         {b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out}, exp);
            end
            if (cyc == 7) begin
                checks++;
                if ({b_rdata, b_err} !== {16'h0000, 1'b1}) begin
                    errors++;
                    $display("FAIL timeout rdata/err: got %h/%b want 0000/1", b_rdata, b_err);
                end
                b_req = 0;
            end
        end

        // ack arriving on the last allowed cycle of each beat must win
        b_req = 1; b_write = 0; b_addr = 12'h0A0; b_ack = 0; b_bus_in = 8'h11;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc <= 2)       exp = pk(1, 0, 0, 0, 1, 3'(cyc - 1), (cyc == 1) ? 8'hA0 : 8'h00);
            else if (cyc <= 6)  exp = pk(0, 0, 1, 0, 1, 3'd0, 8'h00);
            else if (cyc <= 10) exp = pk(0, 0, 1, 0, 1, 3'd1, 8'h00);
            else if (cyc == 11) exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
            else                exp = 16'h0000;
            checks++;
            if ({b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out} !== exp) begin
                errors++;
                $display("FAIL ack_at_limit cyc%0d: got %h want %h", cyc,
                         {b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out}, exp);
            end
            if (cyc == 11) begin
                checks++;
                if ({b_rdata, b_err} !== {16'h2211, 1'b0}) begin
                    errors++;
                    $display("FAIL ack_at_limit rdata/err: got %h/%b want 2211/0", b_rdata, b_err);
                end
                b_req = 0;
            end
            b_ack    = (cyc == 6) || (cyc == 10);
            b_bus_in = (cyc <= 6) ? 8'h11 : 8'h22;
        end
        b_ack = 0;
    endtask

    task automatic test_addr_mask();
        logic [15:0] exp;
        b_req = 1; b_write = 1; b_addr = 12'hFFF; b_wdata = 16'hBEEF; b_ack = 1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            case (cyc)
                1:       exp = pk(1, 0, 0, 0, 1, 3'd0, 8'hFF);
                2:       exp = pk(1, 0, 0, 0, 1, 3'd1, 8'h0F);
                3:       exp = pk(0, 1, 0, 0, 1, 3'd0, 8'hEF);
                4:       exp = pk(0, 1, 0, 0, 1, 3'd1, 8'hBE);
                5:       exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
                default: exp = 16'h0000;
            endcase
            checks++;
            if ({b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out} !== exp) begin
                errors++;
                $display("FAIL addr_mask cyc%0d: got %h want %h", cyc,
                         {b_ale, b_wr, b_rd, b_ready, b_busy, b_beat, b_bus_out}, exp);
            end
            if (cyc == 5) begin
                checks++;
                if ({b_rdata, b_err} !== {16'h2211, 1'b0}) begin
                    errors++;
                    $display("FAIL addr_mask write_keeps_rdata: got %h/%b want 2211/0", b_rdata, b_err);
                end
                b_req = 0;
            end
        end
        b_ack = 0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        a_req = 1; a_write = 1; a_addr = 16'h00C3; a_wdata = 8'h5A; a_ack = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_wr, a_bus_out} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL reset_mid in_wdata: got %h want 15a", {a_wr, a_bus_out});
        end
        #2 a_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_rdata, a_ready, a_err, a_busy, a_bus_out, a_ale, a_wr, a_rd, a_beat} !== 31'd0) begin
            errors++;
            $display("FAIL reset_mid async_clear: got %h want 0",
                     {a_rdata, a_ready, a_err, a_busy, a_bus_out, a_ale, a_wr, a_rd, a_beat});
        end
        @(negedge clk);
        a_rst_n = 1'b1; a_req = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            checks++;
            if ({a_ready, a_busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid no_ready cyc%0d: got %b want 00", cyc, {a_ready, a_busy});
            end
        end
        a_req = 1; a_write = 0; a_addr = 16'h0102; a_ack = 1; a_bus_in = 8'h77;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            case (cyc)
                1:       exp = pk(1, 0, 0, 0, 1, 3'd0, 8'h02);
                2:       exp = pk(1, 0, 0, 0, 1, 3'd1, 8'h01);
                3:       exp = pk(0, 0, 1, 0, 1, 3'd0, 8'h00);
                4:       exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
                default: exp = 16'h0000;
            endcase
            checks++;
            if ({a_ale, a_wr, a_rd, a_ready, a_busy, a_beat, a_bus_out} !== exp) begin
                errors++;
                $display("FAIL after_reset_read cyc%0d: got %h want %h", cyc,
                         {a_ale, a_wr, a_rd, a_ready, a_busy, a_beat, a_bus_out}, exp);
            end
            if (cyc == 4) begin
                checks++;
                if ({a_rdata, a_err} !== {8'h77, 1'b0}) begin
                    errors++;
                    $display("FAIL after_reset_read rdata/err: got %h/%b want 77/0", a_rdata, a_err);
                end
                a_req = 0;
            end
        end
        a_ack = 0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        a_req = 1; a_write = 1; a_addr = 16'h4321; a_wdata = 8'h3C; a_ack = 1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            case (cyc)
                1:       exp = pk(1, 0, 0, 0, 1, 3'd0, 8'h21);
                2:       exp = pk(1, 0, 0, 0, 1, 3'd1, 8'h43);
                3:       exp = pk(0, 1, 0, 0, 1, 3'd0, 8'h3C);
                4:       exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
                5:       exp = 16'h0000;
                6:       exp = pk(1, 0, 0, 0, 1, 3'd0, 8'hAD);
                7:       exp = pk(1, 0, 0, 0, 1, 3'd1, 8'hDE);
                8:       exp = pk(0, 1, 0, 0, 1, 3'd0, 8'h99);
                9:       exp = pk(0, 0, 0, 1, 1, 3'd0, 8'h00);
                default: exp = 16'h0000;
            endcase
            checks++;
            if ({a_ale, a_wr, a_rd, a_ready, a_busy, a_beat, a_bus_out} !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", cyc,
                         {a_ale, a_wr, a_rd, a_ready, a_busy, a_beat, a_bus_out}, exp);
            end
            if (cyc == 1) begin
                a_addr  = 16'hDEAD;
                a_wdata = 8'h99;
            end
            if (cyc == 6) a_req = 0;
        end
        a_ack = 0;
    endtask

    initial begin
        test_reset();
        test_write_default();
        test_read_delayed();
        test_timeout();
        test_addr_mask();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
